// File: rtl/scdp_run_ctrl_if.sv
// Bus between the SCDP run controller and whatever hosts it (bench or FPGA top).
// The host drives the core-side observation signals and start; the controller
// returns the sequencing/status outputs.
// Optional feature macro: SIG_EN adds the 32-bit write-back signature.
interface scdp_run_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic            rd_we;
  logic [XLEN-1:0] rd_wdata;
  logic            core_rst;
  logic [1:0]      state;
  logic            done;
  logic            timeout;
  logic [31:0]     cycle_cnt;
  logic [31:0]     retired;
  logic [XLEN-1:0] halt_pc;
`ifdef SIG_EN
  logic [31:0]     signature;
`endif

  modport master (
    output start, instr, pc, rd_we, rd_wdata,
    input  core_rst, state, done, timeout, cycle_cnt, retired, halt_pc
`ifdef SIG_EN
    , input signature
`endif
  );

  modport slave (
    input  start, instr, pc, rd_we, rd_wdata,
    output core_rst, state, done, timeout, cycle_cnt, retired, halt_pc
`ifdef SIG_EN
    , output signature
`endif
  );
endinterface

// File: rtl/scdp_run_ctrl.sv
// Run controller/monitor for the single-cycle datapath (SCDP).
// Holds the core in reset, releases it for a run, and ends the run on a halt
// instruction (jal x0,0 self-loop seen HALT_REPEAT times at one PC) or when the
// RUN-cycle budget is spent. Counts RUN cycles and retired instructions and
// latches the halt PC. All outputs are registered.
// Optional feature macro: SIG_EN adds the rotating-XOR write-back signature.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | after reset; core held in reset, waiting for start
// S_RESET | core reset held for RST_CYCLES cycles before the run
// S_RUN   | core running; counting cycles/instructions, watching for halt
// S_END   | run finished (done or timeout); core frozen, results held
module scdp_run_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              RST_CYCLES  = 1,
  parameter int              MAX_CYCLES  = 80,
  parameter logic [XLEN-1:0] HALT_INSN   = XLEN'(32'h0000_006F),
  parameter int              HALT_REPEAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  scdp_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_END   = 2'd3
  } state_t;

  localparam int              RCW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int              HRW       = $clog2(HALT_REPEAT + 1);
  localparam logic [RCW-1:0]  RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [HRW-1:0]  HALT_LAST = HRW'(HALT_REPEAT);
  localparam bit              TO_EN     = (MAX_CYCLES != 0);
  // Last budgeted cycle index; only meaningful when the budget is enabled.
  localparam logic [31:0]     TO_LAST   = 32'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

  state_t          state_q;
  logic            core_rst_q;
  logic            done_q;
  logic            timeout_q;
  logic [31:0]     cycle_q;
  logic [31:0]     retired_q;
  logic [XLEN-1:0] halt_pc_q;
  logic [RCW-1:0]  rst_cnt_q;
  logic [HRW-1:0]  halt_run_q;
  logic [XLEN-1:0] prev_pc_q;

  logic            is_halt;
  logic            halt_hit;
  logic            budget_hit;
  logic            restart;
  logic [HRW-1:0]  halt_next;
  logic [31:0]     cycle_inc;
  logic [31:0]     retired_inc;

  assign is_halt    = (bus.instr == HALT_INSN);
  assign restart    = ((state_q == S_IDLE) || (state_q == S_END)) && bus.start;
  assign cycle_inc  = (&cycle_q)   ? cycle_q   : cycle_q + 32'd1;
  assign retired_inc = (&retired_q) ? retired_q : retired_q + 32'd1;
  assign halt_hit   = (halt_next >= HALT_LAST);
  assign budget_hit = TO_EN && (cycle_q == TO_LAST);

  // Length of the current halt self-loop: a halt at a new PC starts a fresh run of 1.
  always_comb begin
    halt_next = '0;
    if (is_halt) begin
      if ((halt_run_q != '0) && (bus.pc == prev_pc_q))
        halt_next = halt_run_q + HRW'(1);
      else
        halt_next = HRW'(1);
    end
  end

  // Sequencer: reset hold, run monitoring, end-of-program detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycle_q    <= '0;
      retired_q  <= '0;
      halt_pc_q  <= '0;
      rst_cnt_q  <= '0;
      halt_run_q <= '0;
      prev_pc_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_END: begin
          core_rst_q <= 1'b1;
          if (restart) begin
            state_q    <= S_RESET;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycle_q    <= '0;
            retired_q  <= '0;
            halt_pc_q  <= '0;
            rst_cnt_q  <= RST_LAST;
            halt_run_q <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt_q == '0) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
          end else begin
            rst_cnt_q  <= rst_cnt_q - RCW'(1);
          end
        end
        S_RUN: begin
          cycle_q    <= cycle_inc;
          halt_run_q <= halt_next;
          prev_pc_q  <= bus.pc;
          if (!is_halt)
            retired_q <= retired_inc;
          // A halt completing on the last budgeted cycle reports as done, not timeout.
          if (halt_hit) begin
            state_q    <= S_END;
            core_rst_q <= 1'b1;
            done_q     <= 1'b1;
            halt_pc_q  <= bus.pc;
          end else if (budget_hit) begin
            state_q    <= S_END;
            core_rst_q <= 1'b1;
            timeout_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          core_rst_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef SIG_EN
  logic [31:0] sig_q;

  // Fold every RUN-cycle register write-back into a rotate-and-XOR signature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sig_q <= '0;
    else if (restart)
      sig_q <= '0;
    else if ((state_q == S_RUN) && bus.rd_we)
      sig_q <= {sig_q[30:0], sig_q[31]} ^ bus.rd_wdata[31:0];
  end

  assign bus.signature = sig_q;
`else
  // Write-back observation is only needed for the signature.
  logic unused_wb;
  assign unused_wb = ^{bus.rd_we, bus.rd_wdata};
`endif

  assign bus.state     = state_q;
  assign bus.core_rst  = core_rst_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.retired   = retired_q;
  assign bus.halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_scdp_run_ctrl.sv
// Scoreboard bench for scdp_run_ctrl. Three controllers with different budgets:
//   dut 0: RST_CYCLES=3, MAX_CYCLES=10   (reset sequencing, halt, timeout, false halt)
//   dut 1: RST_CYCLES=1, MAX_CYCLES=4    (halt vs budget on the same cycle)
//   dut 2: RST_CYCLES=1, MAX_CYCLES=0    (no budget, async reset mid-run)
// Stimulus pushes the expected state transitions; the monitor pops one entry
// each time a controller changes state and compares.
module tb_scdp_run_ctrl;

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_RESET = 2'd1;
  localparam logic [1:0]  ST_RUN   = 2'd2;
  localparam logic [1:0]  ST_END   = 2'd3;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] HALT     = 32'h0000_006F;
`ifdef SIG_EN
  localparam bit          SIGCHK   = 1'b1;
`else
  localparam bit          SIGCHK   = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [1:0]  st;
    logic        crst;
    int          dwell;
    bit          res;
    logic        done;
    logic        tmo;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] hpc;
    bit          csig;
    logic [31:0] sig;
  } exp_t;

  typedef struct {
    logic [1:0]  st;
    logic        crst;
    logic        done;
    logic        tmo;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] hpc;
    logic [31:0] sig;
  } obs_t;

  logic        clk;
  logic [2:0]  rst_v;
  logic [2:0]  start_v;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        rd_we;
  logic [31:0] rd_wdata;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  scdp_run_ctrl_if #(.XLEN(32)) ifa ();
  scdp_run_ctrl_if #(.XLEN(32)) ifb ();
  scdp_run_ctrl_if #(.XLEN(32)) ifc ();

  assign ifa.start = start_v[0];
  assign ifa.instr = instr;
  assign ifa.pc = pc;
  assign ifa.rd_we = rd_we;
  assign ifa.rd_wdata = rd_wdata;
  assign ifb.start = start_v[1];
  assign ifb.instr = instr;
  assign ifb.pc = pc;
  assign ifb.rd_we = rd_we;
  assign ifb.rd_wdata = rd_wdata;
  assign ifc.start = start_v[2];
  assign ifc.instr = instr;
  assign ifc.pc = pc;
  assign ifc.rd_we = rd_we;
  assign ifc.rd_wdata = rd_wdata;

  scdp_run_ctrl #(.XLEN(32), .RST_CYCLES(3), .MAX_CYCLES(10), .HALT_REPEAT(2))
    dut_a (.clk(clk), .rst(rst_v[0]), .bus(ifa));
  scdp_run_ctrl #(.XLEN(32), .RST_CYCLES(1), .MAX_CYCLES(4), .HALT_REPEAT(2))
    dut_b (.clk(clk), .rst(rst_v[1]), .bus(ifb));
  scdp_run_ctrl #(.XLEN(32), .RST_CYCLES(1), .MAX_CYCLES(0), .HALT_REPEAT(2))
    dut_c (.clk(clk), .rst(rst_v[2]), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs_of(input int id);
    obs_t o;
    o.sig = '0;
    case (id)
      0: begin
        o.st = ifa.state; o.crst = ifa.core_rst; o.done = ifa.done; o.tmo = ifa.timeout;
        o.cyc = ifa.cycle_cnt; o.ret = ifa.retired; o.hpc = ifa.halt_pc;
`ifdef SIG_EN
        o.sig = ifa.signature;
`endif
      end
      1: begin
        o.st = ifb.state; o.crst = ifb.core_rst; o.done = ifb.done; o.tmo = ifb.timeout;
        o.cyc = ifb.cycle_cnt; o.ret = ifb.retired; o.hpc = ifb.halt_pc;
`ifdef SIG_EN
        o.sig = ifb.signature;
`endif
      end
      default: begin
        o.st = ifc.state; o.crst = ifc.core_rst; o.done = ifc.done; o.tmo = ifc.timeout;
        o.cyc = ifc.cycle_cnt; o.ret = ifc.retired; o.hpc = ifc.halt_pc;
`ifdef SIG_EN
        o.sig = ifc.signature;
`endif
      end
    endcase
    return o;
  endfunction

  function automatic exp_t mk(input int id, input logic [1:0] st, input logic crst, input int dwell,
                              input bit res, input logic done, input logic tmo,
                              input logic [31:0] cyc, input logic [31:0] ret, input logic [31:0] hpc,
                              input bit csig, input logic [31:0] sig);
    exp_t e;
    e.id = id; e.st = st; e.crst = crst; e.dwell = dwell; e.res = res; e.done = done; e.tmo = tmo;
    e.cyc = cyc; e.ret = ret; e.hpc = hpc; e.csig = csig; e.sig = sig;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic w, input logic [31:0] d);
    instr = i; pc = p; rd_we = w; rd_wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    instr = NOP; pc = '0; rd_we = 1'b0; rd_wdata = '0;
  endtask

  task automatic start_run(input int id);
    start_v[id] = 1'b1;
    @(posedge clk); #1;
    start_v[id] = 1'b0;
  endtask

  task automatic wait_run(input int id);
    bit   ok;
    obs_t o;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      o = obs_of(id);
      if (o.st == ST_RUN) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_run dut%0d: state never reached RUN within 20 cycles, expected RUN", id);
    end
  endtask

  // Monitor: every state change of any controller must match the head of the scoreboard.
  initial begin
    logic [1:0] prev [3];
    int         since [3];
    for (int i = 0; i < 3; i++) begin
      prev[i]  = ST_IDLE;
      since[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        obs_t o;
        exp_t e;
        o = obs_of(i);
        if (o.st !== prev[i]) begin
          if (sb.size() == 0 || sb[0].id != i) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d_transition: got unexpected state %0d, expected no transition", i, o.st);
          end else begin
            e = sb.pop_front();
            chk($sformatf("dut%0d_state", i), 32'(o.st), 32'(e.st));
            chk($sformatf("dut%0d_core_rst(st%0d)", i, e.st), 32'(o.crst), 32'(e.crst));
            if (e.dwell >= 0)
              chk($sformatf("dut%0d_dwell(st%0d)", i, e.st), 32'(since[i]), 32'(e.dwell));
            if (e.res) begin
              chk($sformatf("dut%0d_done(st%0d)", i, e.st), 32'(o.done), 32'(e.done));
              chk($sformatf("dut%0d_timeout(st%0d)", i, e.st), 32'(o.tmo), 32'(e.tmo));
              chk($sformatf("dut%0d_cycle_cnt(st%0d)", i, e.st), o.cyc, e.cyc);
              chk($sformatf("dut%0d_retired(st%0d)", i, e.st), o.ret, e.ret);
              chk($sformatf("dut%0d_halt_pc(st%0d)", i, e.st), o.hpc, e.hpc);
            end
            if (e.csig)
              chk($sformatf("dut%0d_signature(st%0d)", i, e.st), o.sig, e.sig);
          end
          prev[i]  = o.st;
          since[i] = 1;
        end else begin
          since[i]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_v   = 3'b111;
    start_v = 3'b000;
    idle_inputs();
    #2 rst_v = 3'b000;
    #1;
    chk("rst_state", 32'(ifa.state), 32'(ST_IDLE));
    chk("rst_core_rst", 32'(ifa.core_rst), 32'd1);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_timeout", 32'(ifa.timeout), 32'd0);
    chk("rst_cycle_cnt", ifa.cycle_cnt, 32'd0);
    chk("rst_retired", ifa.retired, 32'd0);
    chk("rst_halt_pc", ifa.halt_pc, 32'd0);
`ifdef SIG_EN
    chk("rst_signature", ifa.signature, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_v = 3'b111;
    repeat (2) @(posedge clk);
    #1;

    // Run 1: reset hold of 3 cycles, five NOPs then a two-cycle halt at 0x14.
    // Signature writes 1,2,0x80000000,3: 1 -> 0 -> 0x80000000 -> 0x2.
    sb.push_back(mk(0, ST_RESET, 1'b1, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(0, ST_RUN,   1'b0,  3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(0, ST_END,   1'b1,  7, 1'b1, 1'b1, 1'b0, 7, 5, 32'h14, SIGCHK, 32'h2));
    start_run(0);
    wait_run(0);
    step(NOP,  32'h00, 1'b1, 32'h1);
    step(NOP,  32'h04, 1'b1, 32'h2);
    step(NOP,  32'h08, 1'b1, 32'h8000_0000);
    step(NOP,  32'h0C, 1'b1, 32'h3);
    step(NOP,  32'h10, 1'b0, 32'h0);
    step(HALT, 32'h14, 1'b0, 32'h0);
    step(HALT, 32'h14, 1'b0, 32'h0);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;

    // Run 2: restart from END clears everything; budget of 10 expires; start mid-run ignored.
    sb.push_back(mk(0, ST_RESET, 1'b1, -1, 1'b1, 1'b0, 1'b0, 0, 0, 0, SIGCHK, 32'h0));
    sb.push_back(mk(0, ST_RUN,   1'b0,  3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(0, ST_END,   1'b1, 10, 1'b1, 1'b0, 1'b1, 10, 10, 0, SIGCHK, 32'h0));
    start_run(0);
    wait_run(0);
    for (int k = 0; k < 12; k++) begin
      if (k == 4) start_v[0] = 1'b1;
      step(NOP, 32'(k * 4), 1'b0, 32'h0);
      start_v[0] = 1'b0;
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Run 3: halt at 0x8 then 0xC is not a self-loop; real halt later at 0x14.
    sb.push_back(mk(0, ST_RESET, 1'b1, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(0, ST_RUN,   1'b0,  3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(0, ST_END,   1'b1,  7, 1'b1, 1'b1, 1'b0, 7, 3, 32'h14, 1'b0, 0));
    start_run(0);
    wait_run(0);
    step(NOP,  32'h00, 1'b0, 32'h0);
    step(NOP,  32'h04, 1'b0, 32'h0);
    step(HALT, 32'h08, 1'b0, 32'h0);
    step(HALT, 32'h0C, 1'b0, 32'h0);
    step(NOP,  32'h10, 1'b0, 32'h0);
    step(HALT, 32'h14, 1'b0, 32'h0);
    step(HALT, 32'h14, 1'b0, 32'h0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Run 4: budget 4, halt completes on the 4th RUN cycle -> done wins.
    sb.push_back(mk(1, ST_RESET, 1'b1, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(1, ST_RUN,   1'b0,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(1, ST_END,   1'b1,  4, 1'b1, 1'b1, 1'b0, 4, 2, 32'h08, 1'b0, 0));
    start_run(1);
    wait_run(1);
    step(NOP,  32'h00, 1'b0, 32'h0);
    step(NOP,  32'h04, 1'b0, 32'h0);
    step(HALT, 32'h08, 1'b0, 32'h0);
    step(HALT, 32'h08, 1'b0, 32'h0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Run 5: budget 4, only the first halt cycle lands on the 4th cycle -> timeout.
    sb.push_back(mk(1, ST_RESET, 1'b1, -1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(1, ST_RUN,   1'b0,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(1, ST_END,   1'b1,  4, 1'b1, 1'b0, 1'b1, 4, 3, 32'h0, 1'b0, 0));
    start_run(1);
    wait_run(1);
    step(NOP,  32'h00, 1'b0, 32'h0);
    step(NOP,  32'h04, 1'b0, 32'h0);
    step(NOP,  32'h08, 1'b0, 32'h0);
    step(HALT, 32'h0C, 1'b0, 32'h0);
    step(HALT, 32'h0C, 1'b0, 32'h0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Run 6: no budget, 100 cycles keep running; then async reset mid-run.
    sb.push_back(mk(2, ST_RESET, 1'b1, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    sb.push_back(mk(2, ST_RUN,   1'b0,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    start_run(2);
    wait_run(2);
    for (int k = 0; k < 100; k++)
      step(NOP, 32'(k * 4), 1'b0, 32'h0);
    chk("nobudget_state", 32'(ifc.state), 32'(ST_RUN));
    chk("nobudget_timeout", 32'(ifc.timeout), 32'd0);
    chk("nobudget_cycle_cnt", ifc.cycle_cnt, 32'd100);
    chk("nobudget_retired", ifc.retired, 32'd100);
    chk("nobudget_core_rst", 32'(ifc.core_rst), 32'd0);
    sb.push_back(mk(2, ST_IDLE, 1'b1, -1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0));
    rst_v[2] = 1'b0;
    #1;
    chk("async_rst_state", 32'(ifc.state), 32'(ST_IDLE));
    chk("async_rst_core_rst", 32'(ifc.core_rst), 32'd1);
    chk("async_rst_cycle_cnt", ifc.cycle_cnt, 32'd0);
    @(posedge clk);
    #1 rst_v[2] = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
